// File: rtl/cog_vid_ctrl_pkg.sv
// Shared definitions for the cog_vid sequencer/feeder.
// Holds the bus widths, FSM state encodings, the VID word field offsets
// used by cog_vid, and the packed FIFO entry type.
package cog_vid_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SCL_W  = 20;
  localparam int unsigned SETS_W = 16;
  localparam int unsigned ST_W   = 3;

  // FSM state encodings
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_SCL  = 3'd1;
  localparam logic [ST_W-1:0] ST_VID  = 3'd2;
  localparam logic [ST_W-1:0] ST_RUN  = 3'd3;
  localparam logic [ST_W-1:0] ST_OFF  = 3'd4;

  // VID word field offsets as decoded by cog_vid
  localparam int unsigned VID_MODE_HI  = 30;
  localparam int unsigned VID_MODE_LO  = 29;
  localparam int unsigned VID_GROUP_HI = 10;
  localparam int unsigned VID_GROUP_LO = 9;
  localparam int unsigned VID_PINS_HI  = 7;
  localparam int unsigned VID_PINS_LO  = 0;

  // One FIFO entry: pixel and color words travel together
  typedef struct packed {
    logic [DATA_W-1:0] pixel;
    logic [DATA_W-1:0] color;
  } vid_word_t;

  // Field extractors for a VID configuration word
  function automatic logic [1:0] vid_mode(input logic [DATA_W-1:0] vid);
    return vid[VID_MODE_HI:VID_MODE_LO];
  endfunction

  function automatic logic [1:0] vid_group(input logic [DATA_W-1:0] vid);
    return vid[VID_GROUP_HI:VID_GROUP_LO];
  endfunction

  function automatic logic [7:0] vid_pins(input logic [DATA_W-1:0] vid);
    return vid[VID_PINS_HI:VID_PINS_LO];
  endfunction

endpackage

// File: rtl/cog_vid_ctrl_if.sv
// Cog-side and cog_vid-side signal bundle for cog_vid_ctrl.
// slave  : the controller (receives cfg/start/stop/push/ack, drives vid_* and status)
// master : the cog / environment side
interface cog_vid_ctrl_if
  import cog_vid_ctrl_pkg::*;
#(
  parameter int unsigned LVL_W = 3
);

  logic [DATA_W-1:0] cfg_vid;
  logic [SCL_W-1:0]  cfg_scl;
  logic              start;
  logic              stop;
  logic              push;
  logic [DATA_W-1:0] push_pixel;
  logic [DATA_W-1:0] push_color;
  logic              vid_ack;
  logic              vid_setvid;
  logic              vid_setscl;
  logic [DATA_W-1:0] vid_data;
  logic [DATA_W-1:0] vid_pixel;
  logic [DATA_W-1:0] vid_color;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              busy;
  logic              underrun;
  logic              overflow;
  logic [SETS_W-1:0] sets;

  modport slave (
    input  cfg_vid, cfg_scl, start, stop, push, push_pixel, push_color, vid_ack,
    output vid_setvid, vid_setscl, vid_data, vid_pixel, vid_color,
           full, level, busy, underrun, overflow, sets
  );

  modport master (
    output cfg_vid, cfg_scl, start, stop, push, push_pixel, push_color, vid_ack,
    input  vid_setvid, vid_setscl, vid_data, vid_pixel, vid_color,
           full, level, busy, underrun, overflow, sets
  );

endinterface

// File: rtl/cog_vid_fifo.sv
// DEPTH-entry FIFO of pixel/color pairs for cog_vid_ctrl.
// Ports: clk_cog/nres; push/pop are already qualified by the caller
// (push never arrives on a full FIFO unless pop is also set); flush
// empties the FIFO and wins over push/pop. head_c is the combinational
// head entry; level/full are registered.
module cog_vid_fifo
  import cog_vid_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk_cog,
  input  logic             nres,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  vid_word_t        wdata,
  output vid_word_t        head_c,
  output logic [LVL_W-1:0] level,
  output logic             full
);

  localparam int unsigned PTR_W = LVL_W - 1;

  vid_word_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;

  // Pointer/level update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
    full_d = (level_d == LVL_W'(DEPTH));
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: entries are only read while level > 0
  always_ff @(posedge clk_cog) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head_c = mem_q[rd_ptr_q];
  assign level  = level_q;
  assign full   = full_q;

endmodule

// File: rtl/cog_vid_ctrl.sv
// Sequencer/feeder in front of cog_vid (clk_cog domain).
// On start it programs SCL then VID via one-cycle setscl/setvid strobes,
// then in RUN presents the FIFO head on vid_pixel/vid_color and pops on
// each rising edge of vid_ack. stop writes VID=0 and flushes the FIFO.
// Ports: clk_cog, nres (async active-low) and the cog_vid_ctrl_if slave
// modport carrying config, push data, ack, strobes and status.
// Optional: define COG_VID_CTRL_STATS_EN to build the saturating capture
// counter on bus.sets; otherwise sets reads 0.
module cog_vid_ctrl
  import cog_vid_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic           clk_cog,
  input  logic           nres,
  cog_vid_ctrl_if.slave  bus
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              ack_q;
  logic              setscl_q, setscl_d;
  logic              setvid_q, setvid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;

  logic              cap_edge_c;
  logic              cap_run_c;
  logic              start_clr_c;
  logic              in_off_c;
  logic              fifo_empty_c;
  logic              pop_c;
  logic              push_ok_c;
  logic              ovf_set_c;
  logic              und_set_c;

  vid_word_t         wdata_c;
  vid_word_t         head_c;
  logic [LVL_W-1:0]  level_w;
  logic              full_w;

  // Capture detection and FIFO qualification
  assign cap_edge_c   = bus.vid_ack & ~ack_q;
  assign cap_run_c    = cap_edge_c & (state_q == ST_RUN);
  assign start_clr_c  = bus.start & (state_q == ST_IDLE);
  assign in_off_c     = (state_q == ST_OFF);
  assign fifo_empty_c = (level_w == '0);
  assign pop_c        = cap_run_c & ~fifo_empty_c;
  assign und_set_c    = cap_run_c & fifo_empty_c;
  // A same-cycle pop frees a slot, so a push on a full FIFO still lands
  assign push_ok_c    = bus.push & ~in_off_c & (~full_w | pop_c);
  assign ovf_set_c    = bus.push & ~in_off_c & full_w & ~pop_c;
  assign wdata_c      = '{pixel: bus.push_pixel, color: bus.push_color};

  cog_vid_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_cog (clk_cog),
    .nres    (nres),
    .push    (push_ok_c),
    .pop     (pop_c),
    .flush   (in_off_c),
    .wdata   (wdata_c),
    .head_c  (head_c),
    .level   (level_w),
    .full    (full_w)
  );

  // Next state and registered outputs; strobes follow the state being entered
  always_comb begin
    state_d    = state_q;
    setscl_d   = 1'b0;
    setvid_d   = 1'b0;
    data_d     = data_q;
    pixel_d    = pixel_q;
    color_d    = color_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_SCL;
      ST_SCL:  state_d = ST_VID;
      ST_VID:  state_d = ST_RUN;
      ST_RUN:  if (bus.stop) state_d = ST_OFF;
      ST_OFF:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SCL: begin
        setscl_d = 1'b1;
        data_d   = {{(DATA_W-SCL_W){1'b0}}, bus.cfg_scl};
      end
      ST_VID: begin
        setvid_d = 1'b1;
        data_d   = bus.cfg_vid;
      end
      ST_OFF: begin
        setvid_d = 1'b1;
        data_d   = '0;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);

    // Output words track the head one cycle late and hold while empty
    if (!fifo_empty_c) begin
      pixel_d = head_c.pixel;
      color_d = head_c.color;
    end

    if (start_clr_c) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (und_set_c) underrun_d = 1'b1;
    if (ovf_set_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      setscl_q   <= 1'b0;
      setvid_q   <= 1'b0;
      data_q     <= '0;
      pixel_q    <= '0;
      color_q    <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= bus.vid_ack;
      setscl_q   <= setscl_d;
      setvid_q   <= setvid_d;
      data_q     <= data_d;
      pixel_q    <= pixel_d;
      color_q    <= color_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef COG_VID_CTRL_STATS_EN
  logic [SETS_W-1:0] sets_q, sets_d;

  // Saturating count of captures seen in RUN
  always_comb begin
    sets_d = sets_q;
    if (start_clr_c) begin
      sets_d = '0;
    end else if (cap_run_c && (sets_q != {SETS_W{1'b1}})) begin
      sets_d = sets_q + SETS_W'(1);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) sets_q <= '0;
    else       sets_q <= sets_d;
  end

  assign bus.sets = sets_q;
`else
  assign bus.sets = '0;
`endif

  assign bus.vid_setscl = setscl_q;
  assign bus.vid_setvid = setvid_q;
  assign bus.vid_data   = data_q;
  assign bus.vid_pixel  = pixel_q;
  assign bus.vid_color  = color_q;
  assign bus.full       = full_w;
  assign bus.level      = level_w;
  assign bus.busy       = busy_q;
  assign bus.underrun   = underrun_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_cog_vid_ctrl.sv
// Directed bench for cog_vid_ctrl: a table of per-cycle vectors with
// hand-computed expected outputs, followed by an asynchronous mid-RUN reset.
module tb_cog_vid_ctrl;

  localparam int unsigned LVL_W = 3;
  localparam int unsigned NVEC  = 30;

  localparam logic [31:0] DSCL  = 32'h0000_1004;
  localparam logic [31:0] DVID  = 32'h2000_00FF;
  localparam logic [31:0] CMASK = 32'h5A5A_5A5A;

  localparam logic [31:0] P1  = 32'h1111_0001;
  localparam logic [31:0] P2  = 32'h1111_0002;
  localparam logic [31:0] P3  = 32'h1111_0003;
  localparam logic [31:0] P4  = 32'h1111_0004;
  localparam logic [31:0] P5  = 32'h1111_0005;
  localparam logic [31:0] P6  = 32'h1111_0006;
  localparam logic [31:0] P7  = 32'h1111_0007;
  localparam logic [31:0] P8  = 32'h1111_0008;
  localparam logic [31:0] P9  = 32'h1111_0009;
  localparam logic [31:0] P10 = 32'h1111_000A;
  localparam logic [31:0] P11 = 32'h1111_000B;
  localparam logic [31:0] P12 = 32'h1111_000C;
  localparam logic [31:0] P13 = 32'h1111_000D;

  logic clk_cog;
  logic nres;

  cog_vid_ctrl_if #(.LVL_W(LVL_W)) bus ();

  cog_vid_ctrl #(
    .DEPTH (4),
    .LVL_W (LVL_W)
  ) dut (
    .clk_cog (clk_cog),
    .nres    (nres),
    .bus     (bus)
  );

  initial clk_cog = 1'b0;
  always #5 clk_cog = ~clk_cog;

  typedef struct {
    logic        start;
    logic        stop;
    logic        push;
    logic [31:0] pix;
    logic        ack;
    logic [2:0]  lvl;
    logic        full;
    logic        busy;
    logic        scl;
    logic        vid;
    logic [31:0] data;
    logic [31:0] epix;
    logic        und;
    logic        ovf;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic st, input logic sp, input logic pu,
                              input logic [31:0] pix, input logic ack,
                              input logic [2:0] lvl, input logic full,
                              input logic busy, input logic scl, input logic vid,
                              input logic [31:0] data, input logic [31:0] epix,
                              input logic und, input logic ovf);
    vec_t v;
    v.start = st; v.stop = sp; v.push = pu; v.pix = pix; v.ack = ack;
    v.lvl = lvl; v.full = full; v.busy = busy; v.scl = scl; v.vid = vid;
    v.data = data; v.epix = epix; v.und = und; v.ovf = ovf;
    return v;
  endfunction

  function automatic logic [31:0] exp_color(input logic [31:0] p);
    return (p == 32'h0) ? 32'h0 : (p ^ CMASK);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_cog);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic pu,
                       input logic [31:0] pix, input logic ack);
    bus.start      = st;
    bus.stop       = sp;
    bus.push       = pu;
    bus.push_pixel = pix;
    bus.push_color = pix ^ CMASK;
    bus.vid_ack    = ack;
  endtask

  task automatic check_all_zero(input int idx);
    check("rst_setscl", idx, 32'(bus.vid_setscl), 32'h0);
    check("rst_setvid", idx, 32'(bus.vid_setvid), 32'h0);
    check("rst_data",   idx, bus.vid_data, 32'h0);
    check("rst_pixel",  idx, bus.vid_pixel, 32'h0);
    check("rst_color",  idx, bus.vid_color, 32'h0);
    check("rst_level",  idx, 32'(bus.level), 32'h0);
    check("rst_full",   idx, 32'(bus.full), 32'h0);
    check("rst_busy",   idx, 32'(bus.busy), 32'h0);
    check("rst_under",  idx, 32'(bus.underrun), 32'h0);
    check("rst_over",   idx, 32'(bus.overflow), 32'h0);
    check("rst_sets",   idx, 32'(bus.sets), 32'h0);
  endtask

  initial begin
    //             st sp pu pix  ack  lvl full busy scl vid data  epix und ovf
    vecs[0]  = mk(0, 0, 1, P1,  0,   1,  0,   0,  0,  0,  0,    0,   0,  0);
    vecs[1]  = mk(0, 0, 1, P2,  0,   2,  0,   0,  0,  0,  0,    P1,  0,  0);
    vecs[2]  = mk(1, 0, 0, 0,   0,   2,  0,   1,  1,  0,  DSCL, P1,  0,  0);
    vecs[3]  = mk(0, 0, 0, 0,   0,   2,  0,   1,  0,  1,  DVID, P1,  0,  0);
    vecs[4]  = mk(0, 0, 0, 0,   0,   2,  0,   1,  0,  0,  DVID, P1,  0,  0);
    vecs[5]  = mk(0, 0, 0, 0,   1,   1,  0,   1,  0,  0,  DVID, P1,  0,  0);
    vecs[6]  = mk(0, 0, 0, 0,   1,   1,  0,   1,  0,  0,  DVID, P2,  0,  0);
    vecs[7]  = mk(0, 0, 0, 0,   0,   1,  0,   1,  0,  0,  DVID, P2,  0,  0);
    vecs[8]  = mk(0, 0, 0, 0,   1,   0,  0,   1,  0,  0,  DVID, P2,  0,  0);
    vecs[9]  = mk(0, 0, 0, 0,   0,   0,  0,   1,  0,  0,  DVID, P2,  0,  0);
    vecs[10] = mk(0, 0, 0, 0,   1,   0,  0,   1,  0,  0,  DVID, P2,  1,  0);
    vecs[11] = mk(0, 0, 0, 0,   0,   0,  0,   1,  0,  0,  DVID, P2,  1,  0);
    vecs[12] = mk(0, 0, 1, P3,  0,   1,  0,   1,  0,  0,  DVID, P2,  1,  0);
    vecs[13] = mk(0, 0, 1, P4,  0,   2,  0,   1,  0,  0,  DVID, P3,  1,  0);
    vecs[14] = mk(0, 0, 1, P5,  0,   3,  0,   1,  0,  0,  DVID, P3,  1,  0);
    vecs[15] = mk(0, 0, 1, P6,  0,   4,  1,   1,  0,  0,  DVID, P3,  1,  0);
    vecs[16] = mk(0, 0, 1, P7,  0,   4,  1,   1,  0,  0,  DVID, P3,  1,  1);
    vecs[17] = mk(0, 0, 1, P8,  1,   4,  1,   1,  0,  0,  DVID, P3,  1,  1);
    vecs[18] = mk(0, 0, 0, 0,   0,   4,  1,   1,  0,  0,  DVID, P4,  1,  1);
    vecs[19] = mk(0, 0, 0, 0,   1,   3,  0,   1,  0,  0,  DVID, P4,  1,  1);
    vecs[20] = mk(0, 0, 0, 0,   0,   3,  0,   1,  0,  0,  DVID, P5,  1,  1);
    vecs[21] = mk(0, 1, 0, 0,   0,   3,  0,   1,  0,  1,  0,    P5,  1,  1);
    vecs[22] = mk(0, 0, 0, 0,   0,   0,  0,   0,  0,  0,  0,    P5,  1,  1);
    vecs[23] = mk(1, 0, 0, 0,   0,   0,  0,   1,  1,  0,  DSCL, P5,  0,  0);
    vecs[24] = mk(0, 0, 0, 0,   1,   0,  0,   1,  0,  1,  DVID, P5,  0,  0);
    vecs[25] = mk(0, 0, 1, P9,  0,   1,  0,   1,  0,  0,  DVID, P5,  0,  0);
    vecs[26] = mk(1, 0, 1, P10, 0,   2,  0,   1,  0,  0,  DVID, P9,  0,  0);
    vecs[27] = mk(0, 1, 1, P11, 0,   3,  0,   1,  0,  1,  0,    P9,  0,  0);
    vecs[28] = mk(0, 0, 1, P12, 0,   0,  0,   0,  0,  0,  0,    P9,  0,  0);
    vecs[29] = mk(0, 0, 0, 0,   0,   0,  0,   0,  0,  0,  0,    P9,  0,  0);

    bus.cfg_vid = DVID;
    bus.cfg_scl = 20'h01004;
    drive(0, 0, 0, 32'h0, 0);
    nres = 1'b0;
    step();
    step();
    check_all_zero(0);
    @(negedge clk_cog);
    nres = 1'b1;
    step();
    check_all_zero(1);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].push, vecs[i].pix, vecs[i].ack);
      step();
      check("level",    i, 32'(bus.level),      32'(vecs[i].lvl));
      check("full",     i, 32'(bus.full),       32'(vecs[i].full));
      check("busy",     i, 32'(bus.busy),       32'(vecs[i].busy));
      check("setscl",   i, 32'(bus.vid_setscl), 32'(vecs[i].scl));
      check("setvid",   i, 32'(bus.vid_setvid), 32'(vecs[i].vid));
      check("data",     i, bus.vid_data,        vecs[i].data);
      check("pixel",    i, bus.vid_pixel,       vecs[i].epix);
      check("color",    i, bus.vid_color,       exp_color(vecs[i].epix));
      check("underrun", i, 32'(bus.underrun),   32'(vecs[i].und));
      check("overflow", i, 32'(bus.overflow),   32'(vecs[i].ovf));
`ifndef COG_VID_CTRL_STATS_EN
      check("sets",     i, 32'(bus.sets),       32'h0);
`endif
    end
    drive(0, 0, 0, 32'h0, 0);

    // Asynchronous reset while in RUN with a word on the outputs
    drive(1, 0, 0, 32'h0, 0);
    step();
    drive(0, 0, 0, 32'h0, 0);
    step();
    step();
    drive(0, 0, 1, P13, 0);
    step();
    drive(0, 0, 0, 32'h0, 1);
    step();
    drive(0, 0, 0, 32'h0, 0);
    check("pre_busy",  0, 32'(bus.busy), 32'h1);
    check("pre_pixel", 0, bus.vid_pixel, P13);
    check("pre_level", 0, 32'(bus.level), 32'h0);
`ifdef COG_VID_CTRL_STATS_EN
    check("pre_sets",  0, 32'(bus.sets), 32'h1);
`endif
    @(negedge clk_cog);
    nres = 1'b0;
    #1;
    check_all_zero(2);
    step();
    check_all_zero(3);
    @(negedge clk_cog);
    nres = 1'b1;
    step();
    check("post_busy",   0, 32'(bus.busy), 32'h0);
    check("post_setvid", 0, 32'(bus.vid_setvid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
